// File: rtl/nx_fifo_ctrl_1ar1w.sv
// FIFO controller for an external 1-read/1-write RAM with a registered output stage.
// Capacity is DEPTH words in the RAM plus one word held in rd_data.
module nx_fifo_ctrl_1ar1w #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic [AW-1:0]    ram_ra,
    input  logic [WIDTH-1:0] ram_dout,
    output logic             ram_web,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_din,
    output logic [WIDTH-1:0] ram_bwe
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] ram_cnt;
    logic          push;
    logic          load;
    logic          pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Space is judged on the registered count only, so a pop never frees a slot in the same cycle.
    assign wr_ready = !rst && !flush && (ram_cnt < CW'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign load     = !flush && (ram_cnt != '0) && (!rd_valid || rd_ready);

    assign ram_web  = !push;
    assign ram_wa   = wptr;
    assign ram_din  = wr_data;
    assign ram_bwe  = '1;
    assign ram_ra   = rptr;

    assign level    = LW'(ram_cnt) + LW'(rd_valid);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push) begin
                wptr <= next_ptr(wptr);
            end
            if (load) begin
                rptr     <= next_ptr(rptr);
                rd_data  <= ram_dout;
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            case ({push, load})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_nx_fifo_ctrl_1ar1w.sv
// Scoreboard bench for nx_fifo_ctrl_1ar1w at WIDTH=8, DEPTH=4 with a behavioural RAM.
module tb_nx_fifo_ctrl_1ar1w;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [2:0] level;
    logic [1:0] ram_ra;
    logic [7:0] ram_dout;
    logic       ram_web;
    logic [1:0] ram_wa;
    logic [7:0] ram_din;
    logic [7:0] ram_bwe;

    logic [7:0] mem [4];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    int   m_cnt, m_wp, m_rp;
    bit   m_rdv;
    int   wa_wraps, ra_wraps;
    logic [1:0] last_wa, last_ra;

    always #5 clk = ~clk;

    nx_fifo_ctrl_1ar1w #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .ram_ra(ram_ra), .ram_dout(ram_dout),
        .ram_web(ram_web), .ram_wa(ram_wa), .ram_din(ram_din), .ram_bwe(ram_bwe)
    );

    always @(posedge clk) begin
        if (!ram_web) mem[ram_wa] <= (mem[ram_wa] & ~ram_bwe) | (ram_din & ram_bwe);
    end
    assign ram_dout = mem[ram_ra];

    task automatic model_clear();
        q.delete();
        m_cnt = 0; m_rdv = 0; m_wp = 0; m_rp = 0;
    endtask

    // One clock of stimulus: drive at negedge, compare against the model, then advance it at posedge.
    task automatic step(input bit wv, input logic [7:0] wd, input bit rr, input bit fl);
        bit e_ready, e_push, e_pop, e_load;
        @(negedge clk);
        wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
        #1;
        e_ready = !fl && (m_cnt < 4);
        e_push  = wv && e_ready;
        e_pop   = m_rdv && rr;
        e_load  = !fl && (m_cnt > 0) && (!m_rdv || rr);
        vectors++;
        if (wr_ready !== e_ready) begin
            miscompares++; $display("FAIL step_wr_ready: got %b, want %b", wr_ready, e_ready);
        end
        vectors++;
        if (ram_web !== !e_push) begin
            miscompares++; $display("FAIL step_ram_web: got %b, want %b", ram_web, !e_push);
        end
        vectors++;
        if (level !== 3'(m_cnt + int'(m_rdv))) begin
            miscompares++; $display("FAIL step_level: got %0d, want %0d", level, m_cnt + int'(m_rdv));
        end
        vectors++;
        if (rd_valid !== m_rdv) begin
            miscompares++; $display("FAIL step_rd_valid: got %b, want %b", rd_valid, m_rdv);
        end
        if (m_rdv && q.size() > 0) begin
            vectors++;
            if (rd_data !== q[0]) begin
                miscompares++; $display("FAIL step_rd_data: got %h, want %h", rd_data, q[0]);
            end
        end
        vectors++;
        if (ram_wa !== 2'(m_wp) || ram_ra !== 2'(m_rp)) begin
            miscompares++;
            $display("FAIL step_ram_addr: got wa=%0d ra=%0d, want wa=%0d ra=%0d", ram_wa, ram_ra, m_wp, m_rp);
        end
        if (last_wa == 2'd3 && ram_wa == 2'd0) wa_wraps++;
        if (last_ra == 2'd3 && ram_ra == 2'd0) ra_wraps++;
        last_wa = ram_wa;
        last_ra = ram_ra;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_push) begin
                q.push_back(wd);
                m_wp = (m_wp + 1) % 4;
            end
            if (e_load) begin
                m_rp  = (m_rp + 1) % 4;
                m_rdv = 1'b1;
            end else if (e_pop) begin
                m_rdv = 1'b0;
            end
            m_cnt = m_cnt + int'(e_push) - int'(e_load);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (wr_ready !== 1'b0 || ram_web !== 1'b1 || level !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b web=%b lvl=%0d vld=%b data=%h, want 0 1 0 0 00",
                     wr_ready, ram_web, level, rd_valid, rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        last_wa = 2'd0; last_ra = 2'd0;
    endtask

    task automatic test_single_word();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== 3'd1) begin
            miscompares++;
            $display("FAIL single_word: got vld=%b data=%h lvl=%0d, want 1 a5 1", rd_valid, rd_data, level);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        #2;
        vectors++;
        if (wr_ready !== 1'b0 || level !== 3'd5 || rd_data !== 8'h10) begin
            miscompares++;
            $display("FAIL fill: got rdy=%b lvl=%0d data=%h, want 0 5 10", wr_ready, level, rd_data);
        end
    endtask

    task automatic test_full_pop();
        step(1'b1, 8'h16, 1'b1, 1'b0);
        #2;
        vectors++;
        if (level !== 3'd4 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pop: got lvl=%0d rdy=%b, want 4 1", level, wr_ready);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        #2;
        vectors++;
        if (level !== 3'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got lvl=%0d vld=%b, want 0 0", level, rd_valid);
        end
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL flush_repush: got vld=%b data=%h, want 1 3c", rd_valid, rd_data);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back_wrap();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        last_wa = 2'd0; last_ra = 2'd0;
        wa_wraps = 0; ra_wraps = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (wa_wraps !== 2 || ra_wraps !== 2) begin
            miscompares++;
            $display("FAIL wrap_count: got wa=%0d ra=%0d, want 2 2", wa_wraps, ra_wraps);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        vectors++;
        if (level !== 3'd4) begin
            miscompares++; $display("FAIL areset_pre: got lvl=%0d, want 4", level);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || level !== 3'd0 || wr_ready !== 1'b0 || ram_web !== 1'b1 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL areset: got vld=%b lvl=%0d rdy=%b web=%b data=%h, want 0 0 0 1 00",
                     rd_valid, level, wr_ready, ram_web, rd_data);
        end
        #1 rst = 1'b0;
        model_clear();
        last_wa = 2'd0; last_ra = 2'd0;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
        test_reset();
        test_single_word();
        test_fill();
        test_full_pop();
        test_flush();
        test_back_to_back_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
